// File: rtl/ecc_pkg.sv
// Shared ECC field constants, FSM state encoding and width for the modular divider.
// Pure definitions: no latency, no flow control.
package ecc_pkg;

  localparam int W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [W-1:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/modinv_if.sv
// Request/result bundle for the modular divider: operands and start level in, result and ready out.
// No internal latency; the consumer waits on ready, there is no backpressure.
interface modinv_if;
  import ecc_pkg::*;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] m;
  logic [W-1:0] c;
  logic         ready;

  modport master (output start, a, b, m, input c, ready);
  modport slave  (input start, a, b, m, output c, ready);

endinterface

// File: rtl/modinv_step.sv
// One binary extended-Euclid reduction step (halving or subtraction) with its termination test.
// Purely combinational, zero latency, no flow control.
module modinv_step
  import ecc_pkg::*;
(
  input  logic [W-1:0] u,
  input  logic [W-1:0] v,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] m,
  output logic [W-1:0] u_nxt,
  output logic [W-1:0] v_nxt,
  output logic [W-1:0] x1_nxt,
  output logic [W-1:0] x2_nxt,
  output logic         done,
  output logic [W-1:0] res
);

  // x/2 mod md; odd x is lifted by md first, keeping the carry bit before the shift.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x, input logic [W-1:0] md);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
    return s[W:1];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] md);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) d = d + {1'b0, md};
    return d[W-1:0];
  endfunction

  logic u_one;
  logic v_one;
  logic u_zero;

  assign u_one  = (u == W'(1));
  assign v_one  = (v == W'(1));
  assign u_zero = (u == '0);

  always_comb begin
    u_nxt  = u;
    v_nxt  = v;
    x1_nxt = x1;
    x2_nxt = x2;
    done   = 1'b0;
    res    = '0;
    if (u_one) begin
      done = 1'b1;
      res  = x1;
    end else if (v_one) begin
      done = 1'b1;
      res  = x2;
    end else if (u_zero) begin
      // gcd(a, m) != 1: no inverse exists
      done = 1'b1;
      res  = '0;
    end else if (!u[0]) begin
      u_nxt  = u >> 1;
      x1_nxt = half_mod(x1, m);
    end else if (!v[0]) begin
      v_nxt  = v >> 1;
      x2_nxt = half_mod(x2, m);
    end else if (u >= v) begin
      u_nxt  = u - v;
      x1_nxt = sub_mod(x1, x2, m);
    end else begin
      v_nxt  = v - u;
      x2_nxt = sub_mod(x2, x1, m);
    end
  end

endmodule

// File: rtl/modinv.sv
// Sequential modular divider c = b * a^-1 mod m, one reduction step per clock.
// Latency data-dependent (2 .. 4W+2 cycles) from the start rising edge; start edges during RUN are ignored.
module modinv
  import ecc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  modinv_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]   state;
  logic         start_q;
  logic         start_edge;
  logic [W-1:0] u;
  logic [W-1:0] v;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] mreg;
  logic [W-1:0] c_q;
  logic         ready_q;

  logic [W-1:0] u_nxt;
  logic [W-1:0] v_nxt;
  logic [W-1:0] x1_nxt;
  logic [W-1:0] x2_nxt;
  logic         step_done;
  logic [W-1:0] step_res;

  assign start_edge = bus.start & ~start_q;

  modinv_step u_step (
    .u      (u),
    .v      (v),
    .x1     (x1),
    .x2     (x2),
    .m      (mreg),
    .u_nxt  (u_nxt),
    .v_nxt  (v_nxt),
    .x1_nxt (x1_nxt),
    .x2_nxt (x2_nxt),
    .done   (step_done),
    .res    (step_res)
  );

  // The edge detector resets high so a start level held through reset is not taken as a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      c_q     <= '0;
      start_q <= 1'b1;
    end else begin
      start_q <= bus.start;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            u       <= bus.a;
            v       <= bus.m;
            x1      <= bus.b;
            x2      <= '0;
            mreg    <= bus.m;
            ready_q <= 1'b0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (step_done) begin
            c_q     <= step_res;
            ready_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            u  <= u_nxt;
            v  <= v_nxt;
            x1 <= x1_nxt;
            x2 <= x2_nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.c     = c_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_modinv.sv
// Scoreboard bench for modinv: the driver queues expected results from a Fermat-based model,
// a negedge monitor compares each completed result as ready rises.
module tb_modinv;
  import ecc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modinv_if bus ();
  modinv dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int rises    = 0;
  logic ready_d = 1'b0;
  logic [W-1:0] exp_q[$];
  string        nm_q[$];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: for prime m, b / a = b * a^(m-2) mod m.
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] md);
    logic [2*W-1:0] t;
    t = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    t = t % {{W{1'b0}}, md};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic [W-1:0] md);
    logic [W-1:0] r;
    logic [W-1:0] e;
    r = W'(1);
    e = md - W'(2);
    for (int i = W - 1; i >= 0; i--) begin
      r = mulmod(r, r, md);
      if (e[i]) r = mulmod(r, av, md);
    end
    return mulmod(bv, r, md);
  endfunction

  function automatic logic [W-1:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.ready && !ready_d) begin
      rises++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h with no pending request", bus.c);
      end else begin
        logic [W-1:0] e;
        string        n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        check(n, bus.c, e);
      end
    end
    ready_d = bus.ready;
  end

  task automatic wait_ready(input string nm, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.ready && cyc < 1100);
    if (!bus.ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: ready=0 after %0d cycles, required ready=1", nm, cyc);
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] mv,
                        input logic [W-1:0] exp, input string nm, output int cyc);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = av;
    bus.b = bv;
    bus.m = mv;
    @(negedge clk);
    bus.start = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    wait_ready(nm, cyc);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = rand256();
    bus.b = rand256();
  endtask

  localparam logic [W-1:0] SECP_A =
    256'hfd17fead63b0f73b1f25378af4f4ccf41a26e81bfae64b63492bf47d406c14ad;

  initial begin
    int cyc;
    int r0;
    logic [W-1:0] av, bv, mv, held;
    logic [W-1:0] primes[6];
    primes = '{W'(7), W'(11), W'(13), W'(101), W'(65537), W'(1000003)};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.m = W'(7);
    repeat (3) @(negedge clk);
    check("reset_ready", W'(bus.ready), W'(0));
    check("reset_c", bus.c, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", W'(bus.ready), W'(0));

    run_op(W'(3), W'(1), W'(7), W'(5), "inv_3_mod7", cyc);
    run_op(W'(2), W'(1), W'(7), W'(4), "inv_2_mod7", cyc);
    run_op(W'(3), W'(2), W'(7), W'(3), "div_2by3_mod7", cyc);
    run_op(W'(1), W'(5), W'(7), W'(5), "div_5by1_mod7", cyc);
    check("fast_path_latency", W'(cyc), W'(2));
    run_op(W'(0), W'(5), W'(7), W'(0), "a_zero", cyc);
    check("a_zero_ready", W'(bus.ready), W'(1));

    run_op(SECP_A, W'(1), SECP256K1_P, ref_div(SECP_A, W'(1), SECP256K1_P), "secp_inv", cyc);
    check("secp_inv_product", mulmod(SECP_A, bus.c, SECP256K1_P), W'(1));
    run_op(SECP256K1_P - W'(1), W'(1), SECP256K1_P, SECP256K1_P - W'(1), "secp_pm1", cyc);

    // Start held high through completion: one operation, stable result.
    av = rand256() % SECP256K1_P;
    if (av == '0) av = W'(1);
    bv = rand256() % SECP256K1_P;
    held = ref_div(av, bv, SECP256K1_P);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.m = SECP256K1_P;
    r0 = rises;
    @(negedge clk);
    bus.start = 1'b1;
    exp_q.push_back(held);
    nm_q.push_back("hold_start");
    wait_ready("hold_start", cyc);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.ready || bus.c !== held) begin
        check("hold_stable_c", bus.c, held);
        check("hold_stable_ready", W'(bus.ready), W'(1));
      end
    end
    check("hold_stable_c_end", bus.c, held);
    check("hold_single_op", W'(rises - r0), W'(1));
    bus.start = 1'b0;
    bus.a = W'(3);
    bus.b = W'(1);
    bus.m = W'(7);
    @(negedge clk);
    bus.start = 1'b1;
    exp_q.push_back(W'(5));
    nm_q.push_back("restart_result");
    @(negedge clk);
    check("restart_ready_drop", W'(bus.ready), W'(0));
    wait_ready("restart", cyc);
    @(negedge clk);
    bus.start = 1'b0;

    // Abort a long operation with reset while start stays high.
    @(negedge clk);
    bus.a = SECP_A;
    bus.b = W'(9);
    bus.m = SECP256K1_P;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (20) @(negedge clk);
    check("running_ready", W'(bus.ready), W'(0));
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", W'(bus.ready), W'(0));
    check("abort_c", bus.c, '0);
    @(negedge clk);
    rst = 1'b0;
    r0 = rises;
    repeat (30) @(negedge clk);
    check("no_op_after_reset_ready", W'(bus.ready), W'(0));
    check("no_op_after_reset_rises", W'(rises - r0), W'(0));
    bus.start = 1'b0;
    bus.a = W'(2);
    bus.b = W'(3);
    bus.m = W'(7);
    @(negedge clk);
    bus.start = 1'b1;
    exp_q.push_back(W'(5));
    nm_q.push_back("post_reset_op");
    wait_ready("post_reset_op", cyc);
    @(negedge clk);
    bus.start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      av = rand256() % SECP256K1_P;
      if (av == '0) av = W'(1);
      bv = rand256() % SECP256K1_P;
      run_op(av, bv, SECP256K1_P, ref_div(av, bv, SECP256K1_P), "rand_secp", cyc);
    end
    for (int i = 0; i < 200; i++) begin
      mv = primes[$urandom_range(5, 0)];
      av = W'($urandom_range(32'(mv - W'(1)), 1));
      bv = W'($urandom_range(32'(mv - W'(1)), 0));
      run_op(av, bv, mv, ref_div(av, bv, mv), "rand_small", cyc);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
